rio_enable_sequencer: RTL and testbench

Safety/enable controller between the SPI interface and the motion outputs (stepdir, pwmout) in the rio top level. Supervises host link health from the SPI sync pulse and a debounced external E-stop. Arms outputs only after a stable link, releases channel enables in staggered order, and latches any fault until the host explicitly clears it.

---
 rtl/rio_enable_sequencer.sv | 130 +++++++++++++
 tb/tb_rio_enable_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rio_enable_sequencer.sv
// rio_enable_sequencer: supervises SPI link health and E-stop, staggers channel enables, latches faults
//   clk, rst_n          : system clock, asynchronous active-low reset
//   sync_in             : SPI transfer-complete level (asynchronous)
//   estop_in            : raw E-stop, active high (asynchronous)
//   host_enable         : per-channel enables requested by the host
//   host_clear          : fault-clear request, acted on at its rising edge
//   chan_enable         : gated per-channel enables
//   error               : high while in FAULT
//   estop_latched       : current fault was caused by the E-stop
//   timeout_flag        : link watchdog expired
//   state               : IDLE=00, ARM=01, RUN=10, FAULT=11
module rio_enable_sequencer #(
  parameter int CHANNELS     = 4,
  parameter int TIMEOUT      = 2700000,
  parameter int ARM_SYNCS    = 3,
  parameter int STAGGER      = 27000,
  parameter int ESTOP_FILTER = 270
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sync_in,
  input  logic                estop_in,
  input  logic [CHANNELS-1:0] host_enable,
  input  logic                host_clear,
  output logic [CHANNELS-1:0] chan_enable,
  output logic                error,
  output logic                estop_latched,
  output logic                timeout_flag,
  output logic [1:0]          state
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int AW = $clog2(ARM_SYNCS + 1);
  localparam int SW = $clog2(STAGGER + 1);
  localparam int EW = $clog2(ESTOP_FILTER + 1);
  localparam logic [WW-1:0] TO_MAX = WW'(TIMEOUT);
  localparam logic [AW-1:0] ARM_LAST = AW'(ARM_SYNCS - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(STAGGER - 1);
  localparam logic [EW-1:0] EF_LAST = EW'(ESTOP_FILTER - 1);
  localparam logic [CHANNELS-1:0] ONE = CHANNELS'(1);
  typedef enum logic [1:0] {IDLE = 2'b00, ARM = 2'b01, RUN = 2'b10, FAULT = 2'b11} state_t;
  state_t              state_q;
  logic [2:0]          sync_q;
  logic                edge_d, edge_q;
  logic [WW-1:0]       wd_q, wd_d;
  logic [1:0]          es_sync_q;
  logic [EW-1:0]       es_cnt_q;
  logic                estop_q;
  logic [AW-1:0]       arm_cnt_q;
  logic [SW-1:0]       st_cnt_q;
  logic [CHANNELS-1:0] released_q, released_d;
  logic                hc_q;
  // The watchdog clears on the detected edge itself, so the FSM never sees a stale
  // timeout alongside the registered edge pulse that ended it.
  assign edge_d = sync_q[2:1] == 2'b01;
  assign wd_d = edge_d ? '0 : (wd_q == TO_MAX ? wd_q : wd_q + 1'b1);
  assign released_d = (released_q << 1) | ONE;
  assign state = state_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q       <= '0;
      edge_q       <= 1'b0;
      wd_q         <= '0;
      timeout_flag <= 1'b0;
      es_sync_q    <= '0;
      es_cnt_q     <= '0;
      estop_q      <= 1'b0;
    end else begin
      sync_q       <= {sync_q[1:0], sync_in};
      edge_q       <= edge_d;
      wd_q         <= wd_d;
      timeout_flag <= wd_d == TO_MAX;
      es_sync_q    <= {es_sync_q[0], estop_in};
      es_cnt_q     <= (es_sync_q[1] == estop_q || es_cnt_q == EF_LAST) ? '0 : es_cnt_q + 1'b1;
      if (es_sync_q[1] != estop_q && es_cnt_q == EF_LAST) estop_q <= ~estop_q;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q       <= IDLE;
      chan_enable   <= '0;
      error         <= 1'b0;
      estop_latched <= 1'b0;
      arm_cnt_q     <= '0;
      st_cnt_q      <= '0;
      released_q    <= '0;
      hc_q          <= 1'b0;
    end else begin
      hc_q <= host_clear;
      case (state_q)
        IDLE: begin
          chan_enable <= '0;
          if (estop_q || timeout_flag) arm_cnt_q <= '0;
          else if (edge_q && arm_cnt_q == ARM_LAST) begin
            arm_cnt_q   <= '0;
            st_cnt_q    <= '0;
            released_q  <= ONE;
            chan_enable <= host_enable & ONE;
            state_q     <= ARM;
          end else if (edge_q) arm_cnt_q <= arm_cnt_q + 1'b1;
        end
        ARM, RUN: begin
          if (estop_q || timeout_flag) begin
            state_q       <= FAULT;
            chan_enable   <= '0;
            error         <= 1'b1;
            estop_latched <= estop_q;
          end else if (state_q == RUN || released_q[CHANNELS-1]) begin
            state_q     <= RUN;
            chan_enable <= host_enable;
          end else if (st_cnt_q == ST_LAST) begin
            st_cnt_q    <= '0;
            released_q  <= released_d;
            chan_enable <= host_enable & released_d;
            state_q     <= released_d[CHANNELS-1] ? RUN : ARM;
          end else begin
            st_cnt_q    <= st_cnt_q + 1'b1;
            chan_enable <= host_enable & released_q;
          end
        end
        default: begin
          chan_enable <= '0;
          if (host_clear && !hc_q && !estop_q && !timeout_flag) begin
            state_q       <= IDLE;
            error         <= 1'b0;
            estop_latched <= 1'b0;
            arm_cnt_q     <= '0;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_rio_enable_sequencer.sv
// tb_rio_enable_sequencer: scoreboard bench for the enable sequencer (arming, timeout, E-stop, clear, reset)
module tb_rio_enable_sequencer;
  localparam logic [1:0] S_IDLE = 2'b00, S_ARM = 2'b01, S_RUN = 2'b10, S_FAULT = 2'b11;
  typedef struct {
    string      tag;
    int         at;
    logic [8:0] exp;
  } sb_t;
  logic       clk = 1'b0;
  logic       rst_n, sync_in, estop_in, host_clear;
  logic [3:0] host_enable, chan_enable;
  logic       error, estop_latched, timeout_flag;
  logic [1:0] state;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         t, u, v, c, q, s;
  sb_t        sb[$];
  sb_t        e;
  rio_enable_sequencer #(
    .CHANNELS(4), .TIMEOUT(100), .ARM_SYNCS(3), .STAGGER(10), .ESTOP_FILTER(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sync_in(sync_in), .estop_in(estop_in),
    .host_enable(host_enable), .host_clear(host_clear), .chan_enable(chan_enable),
    .error(error), .estop_latched(estop_latched), .timeout_flag(timeout_flag), .state(state)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask
  task automatic push(input string tag, input int at, input logic [1:0] st, input logic err,
                      input logic el, input logic to, input logic [3:0] ce);
    sb_t n;
    int i = 0;
    n.tag = tag;
    n.at  = at;
    n.exp = {st, err, el, to, ce};
    while (i < sb.size() && sb[i].at <= at) i++;
    sb.insert(i, n);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic sync_gap(input int n);
    sync_in = 1'b1;
    tick(1);
    sync_in = 1'b0;
    tick(n - 1);
  endtask
  always @(negedge clk)
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      check(e.tag, {23'd0, state, error, estop_latched, timeout_flag, chan_enable}, {23'd0, e.exp});
    end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end
  initial begin
    rst_n = 1'b0;
    sync_in = 1'b0;
    estop_in = 1'b0;
    host_clear = 1'b0;
    host_enable = 4'hF;
    tick(3);
    push("reset", cyc, S_IDLE, 0, 0, 0, 4'h0);
    rst_n = 1'b1;
    tick(10);
    sync_gap(50);
    sync_gap(50);
    t = cyc;
    push("arm_pre", t + 3, S_IDLE, 0, 0, 0, 4'h0);
    push("arm_ch0", t + 4, S_ARM, 0, 0, 0, 4'h1);
    push("arm_ch0_hold", t + 13, S_ARM, 0, 0, 0, 4'h1);
    push("arm_ch1", t + 14, S_ARM, 0, 0, 0, 4'h3);
    push("arm_ch1_hold", t + 23, S_ARM, 0, 0, 0, 4'h3);
    push("arm_ch2", t + 24, S_ARM, 0, 0, 0, 4'h7);
    push("arm_ch2_hold", t + 33, S_ARM, 0, 0, 0, 4'h7);
    push("arm_run", t + 34, S_RUN, 0, 0, 0, 4'hF);
    push("to_pre", t + 102, S_RUN, 0, 0, 0, 4'hF);
    push("to_flag", t + 103, S_RUN, 0, 0, 1, 4'hF);
    push("to_fault", t + 104, S_FAULT, 1, 0, 1, 4'h0);
    sync_gap(110);
    push("clr_during_to", t + 112, S_FAULT, 1, 0, 1, 4'h0);
    host_clear = 1'b1;
    tick(1);
    host_clear = 1'b0;
    tick(1);
    push("to_cleared_still_fault", t + 115, S_FAULT, 1, 0, 0, 4'h0);
    sync_gap(10);
    push("clr_to_pre", t + 122, S_FAULT, 1, 0, 0, 4'h0);
    push("clr_to_idle", t + 123, S_IDLE, 0, 0, 0, 4'h0);
    host_clear = 1'b1;
    tick(1);
    host_clear = 1'b0;
    u = cyc;
    push("rearm_two_edges", u + 54, S_IDLE, 0, 0, 0, 4'h0);
    sync_gap(50);
    sync_gap(50);
    v = cyc;
    push("rearm_pre", v + 3, S_IDLE, 0, 0, 0, 4'h0);
    push("rearm_arm", v + 4, S_ARM, 0, 0, 0, 4'h1);
    push("rearm_run", v + 34, S_RUN, 0, 0, 0, 4'hF);
    sync_gap(50);
    c = cyc;
    sync_in = 1'b1;
    host_enable = 4'h5;
    push("run_he_hold", c, S_RUN, 0, 0, 0, 4'hF);
    push("run_he_5", c + 1, S_RUN, 0, 0, 0, 4'h5);
    push("run_he_0", c + 2, S_RUN, 0, 0, 0, 4'h0);
    push("run_he_F", c + 3, S_RUN, 0, 0, 0, 4'hF);
    tick(1);
    sync_in = 1'b0;
    host_enable = 4'h0;
    tick(1);
    host_enable = 4'hF;
    tick(3);
    push("estop_glitch", c + 15, S_RUN, 0, 0, 0, 4'hF);
    estop_in = 1'b1;
    tick(3);
    estop_in = 1'b0;
    tick(12);
    push("estop_pre", c + 26, S_RUN, 0, 0, 0, 4'hF);
    push("estop_fault", c + 27, S_FAULT, 1, 1, 0, 4'h0);
    estop_in = 1'b1;
    tick(10);
    push("clr_during_estop", c + 33, S_FAULT, 1, 1, 0, 4'h0);
    host_clear = 1'b1;
    tick(1);
    host_clear = 1'b0;
    tick(1);
    estop_in = 1'b0;
    tick(13);
    push("clr_estop_pre", c + 45, S_FAULT, 1, 1, 0, 4'h0);
    push("clr_estop_idle", c + 46, S_IDLE, 0, 0, 0, 4'h0);
    host_clear = 1'b1;
    tick(1);
    host_clear = 1'b0;
    tick(3);
    q = cyc;
    sync_gap(30);
    push("gap_timeout_idle", q + 133, S_IDLE, 0, 0, 1, 4'h0);
    push("gap_to_hold", q + 152, S_IDLE, 0, 0, 1, 4'h0);
    push("gap_to_clear", q + 153, S_IDLE, 0, 0, 0, 4'h0);
    push("gap_edge3_idle", q + 154, S_IDLE, 0, 0, 0, 4'h0);
    push("gap_edge4_idle", q + 184, S_IDLE, 0, 0, 0, 4'h0);
    sync_gap(120);
    sync_gap(30);
    sync_gap(30);
    q = cyc;
    push("gap_arm_pre", q + 3, S_IDLE, 0, 0, 0, 4'h0);
    push("gap_arm", q + 4, S_ARM, 0, 0, 0, 4'h1);
    push("rst_pre_arm", q + 15, S_ARM, 0, 0, 0, 4'h3);
    sync_gap(16);
    push("rst_async", cyc, S_IDLE, 0, 0, 0, 4'h0);
    #1;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    sync_gap(50);
    sync_gap(50);
    s = cyc;
    push("sim_arm", s + 4, S_ARM, 0, 0, 0, 4'h1);
    push("sim_run", s + 34, S_RUN, 0, 0, 0, 4'hF);
    push("sim_pre", s + 102, S_RUN, 0, 0, 0, 4'hF);
    push("sim_flag", s + 103, S_RUN, 0, 0, 1, 4'hF);
    push("sim_fault", s + 104, S_FAULT, 1, 1, 1, 4'h0);
    sync_gap(97);
    estop_in = 1'b1;
    tick(10);
    for (int i = 0; i < 200 && sb.size() > 0; i++) tick(1);
    check("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
